// File: rtl/reg_dump_reader.sv
// reg_dump_reader: walks a register file through one read port and streams (addr, data) words.
// Ports: clk/rst_n (sync active-low); start/abort control; rd_addr/rd_data register-file read port;
// dump_valid/dump_ready/dump_addr/dump_data/dump_last output stream; busy/done status.
module reg_dump_reader #(
  parameter int NUM_REGS = 32,
  parameter int ADDR_W = 5,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              abort,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [DATA_W-1:0] rd_data,
  output logic              dump_valid,
  input  logic              dump_ready,
  output logic [ADDR_W-1:0] dump_addr,
  output logic [DATA_W-1:0] dump_data,
  output logic              dump_last,
  output logic              busy,
  output logic              done
);
  typedef enum logic [1:0] {IDLE, READ, HOLD, DONE} state_t;
  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(NUM_REGS - 1);
  state_t state_q, state_d;
  logic [ADDR_W-1:0] idx_q, idx_d, rd_addr_q, rd_addr_d, dump_addr_q, dump_addr_d;
  logic [DATA_W-1:0] dump_data_q, dump_data_d;
  logic dump_valid_q, dump_valid_d, dump_last_q, dump_last_d;
  always_comb begin
    state_d = state_q;
    idx_d = idx_q;
    rd_addr_d = rd_addr_q;
    dump_addr_d = dump_addr_q;
    dump_data_d = dump_data_q;
    dump_valid_d = dump_valid_q;
    dump_last_d = dump_last_q;
    if (state_q != IDLE && abort) begin
      // abort wins over a same-cycle handshake, so the word is dropped uncounted
      state_d = IDLE;
      dump_valid_d = 1'b0;
      rd_addr_d = '0;
    end else begin
      case (state_q)
        IDLE: if (start) begin
          state_d = READ;
          idx_d = '0;
          rd_addr_d = '0;
        end
        READ: begin
          state_d = HOLD;
          dump_data_d = rd_data;
          dump_addr_d = idx_q;
          dump_last_d = idx_q == LAST;
          dump_valid_d = 1'b1;
        end
        HOLD: if (dump_ready) begin
          dump_valid_d = 1'b0;
          state_d = idx_q == LAST ? DONE : READ;
          idx_d = idx_q == LAST ? idx_q : idx_q + 1'b1;
          rd_addr_d = idx_q == LAST ? rd_addr_q : idx_q + 1'b1;
        end
        default: state_d = IDLE;
      endcase
    end
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      idx_q <= '0;
      rd_addr_q <= '0;
      dump_addr_q <= '0;
      dump_data_q <= '0;
      dump_valid_q <= 1'b0;
      dump_last_q <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q <= idx_d;
      rd_addr_q <= rd_addr_d;
      dump_addr_q <= dump_addr_d;
      dump_data_q <= dump_data_d;
      dump_valid_q <= dump_valid_d;
      dump_last_q <= dump_last_d;
    end
  end
  assign rd_addr = rd_addr_q;
  assign dump_valid = dump_valid_q;
  assign dump_addr = dump_addr_q;
  assign dump_data = dump_data_q;
  assign dump_last = dump_last_q;
  assign busy = state_q != IDLE;
  assign done = state_q == DONE;
endmodule

// File: tb/tb_reg_dump_reader.sv
// tb_reg_dump_reader: directed scoreboard bench for reg_dump_reader.
module tb_reg_dump_reader;
  logic clk = 1'b0, rst_n = 1'b0, start = 1'b0, abort = 1'b0, dump_ready = 1'b1;
  logic [4:0] rd_addr, dump_addr;
  logic [31:0] rd_data, dump_data;
  logic dump_valid, dump_last, busy, done;
  logic [31:0] regs [32];
  logic [37:0] q [$];
  logic [37:0] e;
  int n_assert = 0, n_fail = 0, done_cnt = 0, cyc = 0, e0 = 0, dcyc = 0, dprev = 0;

  reg_dump_reader dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .rd_addr(rd_addr), .rd_data(rd_data),
    .dump_valid(dump_valid), .dump_ready(dump_ready), .dump_addr(dump_addr), .dump_data(dump_data),
    .dump_last(dump_last), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;
  assign rd_data = rd_addr == 5'd0 ? 32'd0 : regs[rd_addr];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    if (done) done_cnt++;
    if (!rst_n || (abort && busy)) q.delete();
    else if (dump_valid && dump_ready) begin
      if (q.size() == 0) chk("unexpected_word", {dump_addr, dump_data}, 0);
      else begin
        e = q.pop_front();
        chk("word_addr", dump_addr, e[37:33]);
        chk("word_data", dump_data, e[32:1]);
        chk("word_last", dump_last, e[0]);
      end
    end
  end

  task automatic start_scan();
    for (int k = 0; k < 32; k++)
      q.push_back({5'(k), (k == 0 ? 32'd0 : regs[k]), k == 31});
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    e0 = cyc;
  endtask

  task automatic wait_word(input logic [4:0] a);
    int n = 0;
    @(negedge clk);
    while (!(dump_valid && dump_addr == a) && n < 300) begin
      @(negedge clk);
      n++;
    end
    chk("wait_word_timeout", n < 300, 1);
  endtask

  task automatic wait_done();
    int n = 0;
    @(negedge clk);
    while (!done && n < 300) begin
      @(negedge clk);
      n++;
    end
    chk("wait_done_timeout", n < 300, 1);
    dcyc = cyc;
  endtask

  initial begin
    for (int k = 0; k < 32; k++) regs[k] = 32'hA500_0000 + k;
    start = 1'b1;
    repeat (2) @(posedge clk);
    #1 chk("reset_outputs", {rd_addr, dump_valid, dump_addr, dump_data, dump_last, busy, done}, 0);
    rst_n = 1'b1;
    start = 1'b0;
    repeat (3) @(posedge clk);
    #1 chk("idle_after_reset", {busy, dump_valid, done}, 0);
    // full scan with ready held high
    dprev = done_cnt;
    start_scan();
    wait_done();
    chk("done_timing", dcyc - e0, 64);
    chk("scan1_queue_empty", q.size(), 0);
    @(posedge clk);
    #1 chk("done_one_cycle", {done, busy}, 0);
    chk("scan1_done_count", done_cnt - dprev, 1);
    // backpressure on word 7 while regs[7] is overwritten
    dprev = done_cnt;
    start_scan();
    wait_word(6);
    @(posedge clk);
    #1 dump_ready = 1'b0;
    wait_word(7);
    regs[7] = 32'hDEADBEEF;
    for (int i = 0; i < 5; i++) begin
      if (i > 0) @(negedge clk);
      chk("bp_hold", {dump_valid, dump_addr, dump_data}, {1'b1, 5'd7, 32'hA500_0007});
    end
    @(posedge clk);
    #1 dump_ready = 1'b1;
    wait_done();
    chk("bp_queue_empty", q.size(), 0);
    @(posedge clk);
    #1 chk("bp_done_count", done_cnt - dprev, 1);
    // abort while holding word 12 with ready high
    dprev = done_cnt;
    start_scan();
    wait_word(11);
    @(posedge clk);
    @(posedge clk);
    #1 chk("abort_hold_word12", {dump_valid, dump_addr}, {1'b1, 5'd12});
    abort = 1'b1;
    @(posedge clk);
    #1 abort = 1'b0;
    chk("abort_idle", {dump_valid, busy, rd_addr}, 0);
    repeat (10) @(posedge clk);
    #1 chk("abort_no_done", done_cnt - dprev, 0);
    chk("abort_still_idle", busy, 0);
    start_scan();
    wait_done();
    chk("restart_queue_empty", q.size(), 0);
    @(posedge clk);
    #1 chk("restart_done_count", done_cnt - dprev, 1);
    // start while busy and on the done cycle is ignored
    dprev = done_cnt;
    start_scan();
    wait_word(3);
    @(posedge clk);
    #1 start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    wait_done();
    chk("busy_start_timing", dcyc - e0, 64);
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    chk("start_on_done_ignored", {busy, done}, 0);
    chk("busy_start_done_count", done_cnt - dprev, 1);
    chk("busy_start_queue_empty", q.size(), 0);
    start_scan();
    wait_done();
    chk("second_scan_timing", dcyc - e0, 64);
    @(posedge clk);
    #1 chk("second_scan_done_count", done_cnt - dprev, 2);
    // synchronous reset during READ of word 20
    dprev = done_cnt;
    start_scan();
    wait_word(19);
    @(posedge clk);
    #1 chk("reset_in_read20", {busy, dump_valid, rd_addr}, {1'b1, 1'b0, 5'd20});
    rst_n = 1'b0;
    @(posedge clk);
    #1 rst_n = 1'b1;
    chk("midscan_reset_outputs", {rd_addr, dump_valid, dump_addr, dump_data, dump_last, busy, done}, 0);
    repeat (80) @(posedge clk);
    #1 chk("reset_no_resume", {busy, dump_valid}, 0);
    chk("reset_no_done", done_cnt - dprev, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
